// File: rtl/frog_game_ctrl.sv
// Frog game controller: collision/goal detection, lives, one-hot level and the hit/goal/over/win FSM.
// Optional SCORE_EN macro adds a saturating 8-bit goal counter on output port score.
module frog_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pause,
    input  logic [7:0][7:0] obs,
    input  logic [2:0]      frogRow,
    input  logic [2:0]      frogCol,
    output logic            resetGame,
    output logic [3:0]      level,
    output logic [1:0]      lives,
    output logic            hit,
    output logic            freeze,
    output logic            gameOver,
    output logic            win
`ifdef SCORE_EN
    ,
    output logic [7:0]      score
`endif
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {S_PLAY, S_HIT, S_GOAL, S_OVER, S_WIN} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_hold, w_hold_nx;
    logic [3:0]    r_level, w_level_nx;
    logic [1:0]    r_lives, w_lives_nx;
    logic          r_rg, w_rg_nx;
    logic          r_hit, w_hit_nx;
    logic          r_freeze, w_freeze_nx;
    logic          r_go, w_go_nx;
    logic          r_win, w_win_nx;
    logic          w_coll, w_goal, w_hold_done;

    assign w_coll      = obs[frogRow][frogCol];
    assign w_goal      = (frogRow == 3'd7) & ~w_coll;
    assign w_hold_done = (r_hold == CW'(HOLD_CYCLES - 1));

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_level_nx = r_level;
        w_lives_nx = r_lives;
        w_rg_nx    = 1'b0;
        w_hit_nx   = 1'b0;
        w_go_nx    = r_go;
        w_win_nx   = r_win;
        case (r_state)
            S_PLAY: begin
                // Collision wins over a simultaneous goal
                if (!pause && w_coll) begin
                    w_hit_nx = 1'b1;
                    if (r_lives > 2'd1) begin
                        w_state_nx = S_HIT;
                        w_lives_nx = r_lives - 2'd1;
                        w_hold_nx  = '0;
                    end else begin
                        w_state_nx = S_OVER;
                        w_lives_nx = 2'd0;
                        w_go_nx    = 1'b1;
                    end
                end else if (!pause && w_goal) begin
                    w_state_nx = S_GOAL;
                    w_hold_nx  = '0;
                end
            end
            S_HIT, S_GOAL: begin
                if (!pause) begin
                    if (!w_hold_done) begin
                        w_hold_nx = r_hold + CW'(1);
                    end else begin
                        w_hold_nx = '0;
                        if (r_state == S_GOAL && r_level[3]) begin
                            w_state_nx = S_WIN;
                            w_win_nx   = 1'b1;
                        end else begin
                            w_state_nx = S_PLAY;
                            w_rg_nx    = 1'b1;
                            if (r_state == S_GOAL) w_level_nx = {r_level[2:0], 1'b0};
                        end
                    end
                end
            end
            default: ;
        endcase
        w_freeze_nx = (w_state_nx != S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_PLAY;
            r_hold   <= '0;
            r_level  <= 4'b0001;
            r_lives  <= 2'(LIVES);
            r_rg     <= 1'b0;
            r_hit    <= 1'b0;
            r_freeze <= 1'b0;
            r_go     <= 1'b0;
            r_win    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_hold   <= w_hold_nx;
            r_level  <= w_level_nx;
            r_lives  <= w_lives_nx;
            r_rg     <= w_rg_nx;
            r_hit    <= w_hit_nx;
            r_freeze <= w_freeze_nx;
            r_go     <= w_go_nx;
            r_win    <= w_win_nx;
        end
    end

    assign resetGame = r_rg;
    assign level     = r_level;
    assign lives     = r_lives;
    assign hit       = r_hit;
    assign freeze    = r_freeze;
    assign gameOver  = r_go;
    assign win       = r_win;

`ifdef SCORE_EN
    logic [7:0] r_score;
    logic       w_score_inc;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_score_inc = (r_state == S_PLAY) && (w_state_nx == S_GOAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= 8'd0;
        end else if (w_score_inc) begin
            r_score <= sat_inc8(r_score);
        end
    end

    assign score = r_score;
`endif

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Scoreboard bench for frog_game_ctrl: a game-level model predicts every cycle's outputs, a monitor compares.
module tb_frog_game_ctrl;
    localparam int LIVES = 3;
    localparam int HOLD  = 4;
    localparam int MP = 0, MH = 1, MG = 2, MO = 3, MW = 4;

    logic            clk = 1'b0;
    logic            reset, pause;
    logic [7:0][7:0] obs;
    logic [2:0]      frogRow, frogCol;
    logic            resetGame, hit, freeze, gameOver, win;
    logic [3:0]      level;
    logic [1:0]      lives;
`ifdef SCORE_EN
    logic [7:0]      score;
`endif

    always #5 clk = ~clk;

    frog_game_ctrl #(.LIVES(LIVES), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .pause(pause), .obs(obs),
        .frogRow(frogRow), .frogCol(frogCol),
        .resetGame(resetGame), .level(level), .lives(lives), .hit(hit),
        .freeze(freeze), .gameOver(gameOver), .win(win)
`ifdef SCORE_EN
        , .score(score)
`endif
    );

    typedef struct packed {
        logic       rg;
        logic [3:0] level;
        logic [1:0] lives;
        logic       hit;
        logic       frz;
        logic       go;
        logic       win;
        logic [7:0] score;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Game-level reference: mode, completed hold cycles, level index, lives, score
    int m_mode, m_held, m_lvl, m_lives, m_score;
    bit m_hit, m_rg, m_go, m_win;

    task automatic model_step(input bit rst, input bit p, input logic [7:0][7:0] ob,
                              input logic [2:0] fr, input logic [2:0] fc);
        bit coll, goal;
        coll = ob[fr][fc];
        goal = (fr == 3'd7) && !coll;
        if (rst) begin
            m_mode = MP; m_lvl = 0; m_lives = LIVES; m_held = 0; m_score = 0;
            m_hit = 0; m_rg = 0; m_go = 0; m_win = 0;
        end else begin
            m_hit = 0; m_rg = 0;
            if (!p) begin
                if (m_mode == MP) begin
                    if (coll) begin
                        m_lives = m_lives - 1;
                        m_hit = 1;
                        if (m_lives == 0) begin m_mode = MO; m_go = 1; end
                        else begin m_mode = MH; m_held = 0; end
                    end else if (goal) begin
                        m_mode = MG; m_held = 0;
                        if (m_score < 255) m_score = m_score + 1;
                    end
                end else if (m_mode == MH || m_mode == MG) begin
                    m_held = m_held + 1;
                    if (m_held == HOLD) begin
                        if (m_mode == MG && m_lvl == 3) begin
                            m_mode = MW; m_win = 1;
                        end else begin
                            if (m_mode == MG) m_lvl = m_lvl + 1;
                            m_mode = MP; m_rg = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.rg    = m_rg;
        e.level = 4'(1 << m_lvl);
        e.lives = 2'(m_lives);
        e.hit   = m_hit;
        e.frz   = (m_mode != MP);
        e.go    = m_go;
        e.win   = m_win;
`ifdef SCORE_EN
        e.score = 8'(m_score);
`else
        e.score = 8'd0;
`endif
        return e;
    endfunction

    task automatic drive(input bit rst, input bit p, input logic [7:0][7:0] ob,
                         input logic [2:0] fr, input logic [2:0] fc);
        @(negedge clk);
        reset = rst; pause = p; obs = ob; frogRow = fr; frogCol = fc;
        model_step(rst, p, ob, fr, fc);
        q.push_back(model_out());
    endtask

    // Monitor: one expected snapshot per edge, sampled 1 time unit after it
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a.rg = resetGame; a.level = level; a.lives = lives; a.hit = hit;
                a.frz = freeze; a.go = gameOver; a.win = win;
`ifdef SCORE_EN
                a.score = score;
`else
                a.score = 8'd0;
`endif
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs@cyc%0d got rg=%b lvl=%b lives=%0d hit=%b frz=%b go=%b win=%b score=%0d expected rg=%b lvl=%b lives=%0d hit=%b frz=%b go=%b win=%b score=%0d",
                             cyc, a.rg, a.level, a.lives, a.hit, a.frz, a.go, a.win, a.score,
                             e.rg, e.level, e.lives, e.hit, e.frz, e.go, e.win, e.score);
                end
            end
        end
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [7:0][7:0] ob;
        logic [2:0]      fr, fc;
        bit              p, r;
        bit              seen_win;
        reset = 1'b1; pause = 1'b0; obs = '0; frogRow = 3'd0; frogCol = 3'd0;

        ob = '0;
        drive(1, 0, ob, 3'd0, 3'd0);
        drive(1, 0, ob, 3'd0, 3'd0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (level !== 4'b0001 || lives !== 2'(LIVES) || hit !== 1'b0 || resetGame !== 1'b0 ||
            freeze !== 1'b0 || gameOver !== 1'b0 || win !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got lvl=%b lives=%0d hit=%b rg=%b frz=%b go=%b win=%b",
                     level, lives, hit, resetGame, freeze, gameOver, win);
        end

        // Repeated collision at (3,5): three hits down to game over, then idle in OVER
        ob[3][5] = 1'b1;
        for (int i = 0; i < 24; i++) drive(0, 0, ob, 3'd3, 3'd5);
        drive(1, 0, ob, 3'd0, 3'd0);

        // Paused collision, then release; pause inside the hold
        for (int i = 0; i < 6; i++) drive(0, 1, ob, 3'd3, 3'd5);
        drive(0, 0, ob, 3'd3, 3'd5);
        for (int i = 0; i < 3; i++) drive(0, 1, ob, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) drive(0, 0, ob, 3'd0, 3'd0);
        drive(1, 0, ob, 3'd0, 3'd0);

        // Goal seeking on row 7 with random pauses and occasional collisions on the goal row
        for (int i = 0; i < 90; i++) begin
            for (int rr = 0; rr < 7; rr++) ob[rr] = 8'($urandom) & 8'($urandom);
            fc = 3'($urandom_range(0, 7));
            ob[7] = 8'd0;
            if ($urandom_range(0, 19) == 0) ob[7][fc] = 1'b1;
            p = ($urandom_range(0, 3) == 0);
            drive(0, p, ob, 3'd7, fc);
        end
        drive(1, 0, ob, 3'd0, 3'd0);

        // Clean four-goal run to WIN, then hold
        ob = '0;
        seen_win = 1'b0;
        for (int i = 0; i < 45; i++) begin
            drive(0, 0, ob, 3'd7, 3'd2);
            if (i < 40 && win === 1'b1) seen_win = 1'b1;
        end
        n_cmp++;
        if (!seen_win) begin
            n_bad++;
            $display("FAIL wait_win_timeout: win not asserted within 40 cycles");
        end
        drive(1, 0, ob, 3'd0, 3'd0);

        // Fully random play with occasional resets
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 150; i++) begin
                for (int rr = 0; rr < 8; rr++) ob[rr] = 8'($urandom) & 8'($urandom);
                fr = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
                fc = 3'($urandom_range(0, 7));
                p  = ($urandom_range(0, 4) == 0);
                r  = ($urandom_range(0, 39) == 0);
                drive(r, p, ob, fr, fc);
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
